// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - 2-FF synchronised per-key debouncer with level, pin-polarity level and press/release pulses.
// Optional auto-repeat of key_press is enabled by defining KEY_DEBOUNCE_REPEAT_EN.
module key_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_pio,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam logic [N_KEYS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] p;
    logic [N_KEYS-1:0] s;
    logic [N_KEYS-1:0] s_nxt;
    logic [CNT_W-1:0]  cnt     [N_KEYS];
    logic [CNT_W-1:0]  cnt_nxt [N_KEYS];
    logic [N_KEYS-1:0] rep_fire;

    // Normalised so that 1 always means pressed, whatever the pin polarity.
    assign p = sync2 ^ INACTIVE;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= INACTIVE;
            sync2 <= INACTIVE;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    always_comb begin
        s_nxt = s;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_nxt[i] = '0;
            if (p[i] != s[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    s_nxt[i] = p[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s <= s_nxt;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 2);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 2);

    logic [RPT_W-1:0]  rpt [N_KEYS];
    logic [N_KEYS-1:0] rpt_on;

    // rpt restarts the cycle after each press pulse, so firing at limit-2 lands exactly one delay after the pulse.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            rep_fire[i] = s[i] & key_level[i] & ~key_press[i]
                        & (rpt[i] == (rpt_on[i] ? RPT_NEXT : RPT_FIRST));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_on <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                rpt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (!key_level[i] || key_press[i]) begin
                    rpt[i] <= '0;
                end else begin
                    rpt[i] <= rpt[i] + RPT_W'(1);
                end
                if (!key_level[i]) begin
                    rpt_on[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rpt_on[i] <= 1'b1;
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    // Edge pulses come from comparing the stable state with the registered level it is about to replace.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_level   <= '0;
            key_pio     <= INACTIVE;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_level   <= s;
            key_pio     <= s ^ INACTIVE;
            key_press   <= (s & ~key_level) | rep_fire;
            key_release <= ~s & key_level;
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - scoreboard bench for key_debouncer (DEBOUNCE_CYCLES=8, active-low, repeat 20/6).
module tb_key_debouncer;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
        logic [3:0] pio;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_in;
    logic [3:0] key_pio;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int  cyc = 0;
    int  total = 0;
    int  passed = 0;
    ev_t q[$];

    key_debouncer #(
        .N_KEYS(4),
        .DEBOUNCE_CYCLES(8),
        .CNT_W(20),
        .ACTIVE_LOW(1),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_in(key_in),
        .key_pio(key_pio),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push(int c, logic [3:0] press, logic [3:0] rel, logic [3:0] level);
        ev_t e;
        e.cyc   = c;
        e.press = press;
        e.rel   = rel;
        e.level = level;
        e.pio   = ~level;
        q.push_back(e);
    endtask

    task automatic wait_n(int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && ((key_press | key_release) != 4'h0)) begin
            if (q.size() == 0) begin
                chk("spurious_event", int'({key_press, key_release}), 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("key_press", int'(key_press), int'(e.press));
                chk("key_release", int'(key_release), int'(e.rel));
                chk("key_level", int'(key_level), int'(e.level));
                chk("key_pio", int'(key_pio), int'(e.pio));
            end
        end
    end

    initial begin
        int a;
        reset  = 1'b1;
        key_in = 4'b0000;
        wait_n(3);
        chk("reset_pio", int'(key_pio), 15);
        chk("reset_level", int'(key_level), 0);
        chk("reset_press", int'(key_press), 0);
        chk("reset_release", int'(key_release), 0);

        // all keys held through reset
        reset = 1'b0;
        push(cyc + 11, 4'hF, 4'h0, 4'hF);
        wait_n(20);
        key_in = 4'hF;
        push(cyc + 11, 4'h0, 4'hF, 4'h0);
        wait_n(20);

        // clean press/release on key 0
        key_in = 4'b1110;
        push(cyc + 11, 4'b0001, 4'h0, 4'b0001);
        wait_n(30);
        key_in = 4'hF;
        push(cyc + 11, 4'h0, 4'b0001, 4'h0);
        wait_n(20);

        // bounce on key 1
        for (int i = 0; i < 3; i++) begin
            key_in[1] = 1'b0;
            wait_n(5);
            key_in[1] = 1'b1;
            wait_n(2);
        end
        key_in[1] = 1'b0;
        push(cyc + 11, 4'b0010, 4'h0, 4'b0010);
        wait_n(20);
        key_in = 4'hF;
        push(cyc + 11, 4'h0, 4'b0010, 4'h0);
        wait_n(20);

        // keys 2 and 3 together, key 2 let go early
        key_in = 4'b0011;
        push(cyc + 11, 4'b1000, 4'h0, 4'b1000);
        wait_n(4);
        key_in = 4'b0111;
        wait_n(20);
        key_in = 4'hF;
        push(cyc + 11, 4'h0, 4'b1000, 4'h0);
        wait_n(20);

        // reset mid-count, then hold for the repeat scenario
        key_in = 4'b1110;
        wait_n(7);
        chk("midcount_level", int'(key_level), 0);
        reset = 1'b1;
        wait_n(2);
        reset = 1'b0;
        a = cyc + 11;
        push(a, 4'b0001, 4'h0, 4'b0001);
`ifdef KEY_DEBOUNCE_REPEAT_EN
        for (int t = a + 20; t < a + 71; t += 6) begin
            push(t, 4'b0001, 4'h0, 4'b0001);
        end
`endif
        wait_n(71);
        key_in = 4'hF;
        push(cyc + 11, 4'h0, 4'b0001, 4'h0);
        wait_n(25);

        chk("events_outstanding", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
